// File: rtl/burst_rr_arbiter_pkg.sv
// Shared definitions for the burst arbiter family: FSM state encoding and field width default.
package burst_rr_arbiter_pkg;

   localparam int unsigned OffsetWDefault = 3;

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } arb_state_e;

endpackage

// File: rtl/burst_rr_arbiter_rr_grant2.sv
// Two-way round-robin grant: the requester named by prio_i wins, the other only when it is idle.
module burst_rr_arbiter_rr_grant2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic [1:0] grant_o
);

   logic other;

   assign other = ~prio_i;

   always_comb begin
      grant_o = '0;
      if (valid_i[prio_i]) begin
         grant_o[prio_i] = 1'b1;
      end else if (valid_i[other]) begin
         grant_o[other] = 1'b1;
      end
   end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Two-requester burst arbiter: accepts one command at a time and expands it into wrapping beats.
module burst_rr_arbiter
   import burst_rr_arbiter_pkg::*;
#(
   parameter int unsigned OFFSET_W = OffsetWDefault
) (
   input  logic                clock,
   input  logic                reset,

   input  logic                io_in_0_valid,
   input  logic                io_in_0_bits_id,
   input  logic [OFFSET_W-1:0] io_in_0_bits_offset,
   input  logic [OFFSET_W-1:0] io_in_0_bits_len,
   output logic                io_in_0_ready,

   input  logic                io_in_1_valid,
   input  logic                io_in_1_bits_id,
   input  logic [OFFSET_W-1:0] io_in_1_bits_offset,
   input  logic [OFFSET_W-1:0] io_in_1_bits_len,
   output logic                io_in_1_ready,

   input  logic                io_out_ready,
   output logic                io_out_valid,
   output logic                io_out_bits_id,
   output logic [OFFSET_W-1:0] io_out_bits_offset,
   output logic                io_out_bits_last,
   output logic                io_out_bits_src
);

   arb_state_e          state_q, state_d;
   logic                ptr_q, ptr_d;
   logic [OFFSET_W-1:0] beat_q, beat_d;
   logic [OFFSET_W-1:0] len_q, len_d;

   logic                out_valid_q, out_valid_d;
   logic                out_id_q, out_id_d;
   logic [OFFSET_W-1:0] out_offset_q, out_offset_d;
   logic                out_last_q, out_last_d;
   logic                out_src_q, out_src_d;

   logic [1:0]          valid;
   logic [1:0]          grant;
   logic                idle;
   logic                accept;
   logic                out_fire;
   logic                sel;
   logic [OFFSET_W-1:0] sel_len;

   assign valid = {io_in_1_valid, io_in_0_valid};

   burst_rr_arbiter_rr_grant2 u_grant (
      .valid_i (valid),
      .prio_i  (ptr_q),
      .grant_o (grant)
   );

   assign idle     = (state_q == StIdle);
   assign accept   = idle & (|grant);
   assign out_fire = (state_q == StBurst) & io_out_ready;
   assign sel      = grant[1];
   assign sel_len  = sel ? io_in_1_bits_len : io_in_0_bits_len;

   assign io_in_0_ready = idle & grant[0];
   assign io_in_1_ready = idle & grant[1];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      beat_d       = beat_q;
      len_d        = len_q;
      out_valid_d  = out_valid_q;
      out_id_d     = out_id_q;
      out_offset_d = out_offset_q;
      out_last_d   = out_last_q;
      out_src_d    = out_src_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d      = StBurst;
               ptr_d        = ~sel;
               beat_d       = '0;
               len_d        = sel_len;
               out_valid_d  = 1'b1;
               out_id_d     = sel ? io_in_1_bits_id : io_in_0_bits_id;
               out_offset_d = sel ? io_in_1_bits_offset : io_in_0_bits_offset;
               out_last_d   = (sel_len == '0);
               out_src_d    = sel;
            end
         end
         StBurst: begin
            if (out_fire) begin
               if (out_last_q) begin
                  // Returning to idle blocks acceptance for one cycle, giving the bubble.
                  state_d      = StIdle;
                  out_valid_d  = 1'b0;
                  out_id_d     = 1'b0;
                  out_offset_d = '0;
                  out_last_d   = 1'b0;
                  out_src_d    = 1'b0;
               end else begin
                  beat_d       = beat_q + OFFSET_W'(1);
                  out_offset_d = out_offset_q + OFFSET_W'(1);
                  out_last_d   = ((beat_q + OFFSET_W'(1)) == len_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= StIdle;
         ptr_q        <= 1'b0;
         beat_q       <= '0;
         len_q        <= '0;
         out_valid_q  <= 1'b0;
         out_id_q     <= 1'b0;
         out_offset_q <= '0;
         out_last_q   <= 1'b0;
         out_src_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         beat_q       <= beat_d;
         len_q        <= len_d;
         out_valid_q  <= out_valid_d;
         out_id_q     <= out_id_d;
         out_offset_q <= out_offset_d;
         out_last_q   <= out_last_d;
         out_src_q    <= out_src_d;
      end
   end

   assign io_out_valid       = out_valid_q;
   assign io_out_bits_id     = out_id_q;
   assign io_out_bits_offset = out_offset_q;
   assign io_out_bits_last   = out_last_q;
   assign io_out_bits_src    = out_src_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed self-checking bench for burst_rr_arbiter.
module tb_burst_rr_arbiter;

   localparam int unsigned W = 3;

   logic         clock = 1'b0;
   logic         reset;
   logic         v0, id0, v1, id1;
   logic [W-1:0] off0, len0, off1, len1;
   logic         rdy0, rdy1;
   logic         out_ready;
   logic         out_valid, out_id, out_last, out_src;
   logic [W-1:0] out_offset;

   int n_checks = 0;
   int n_fail   = 0;

   burst_rr_arbiter #(
      .OFFSET_W (W)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .io_in_0_valid       (v0),
      .io_in_0_bits_id     (id0),
      .io_in_0_bits_offset (off0),
      .io_in_0_bits_len    (len0),
      .io_in_0_ready       (rdy0),
      .io_in_1_valid       (v1),
      .io_in_1_bits_id     (id1),
      .io_in_1_bits_offset (off1),
      .io_in_1_bits_len    (len1),
      .io_in_1_ready       (rdy1),
      .io_out_ready        (out_ready),
      .io_out_valid        (out_valid),
      .io_out_bits_id      (out_id),
      .io_out_bits_offset  (out_offset),
      .io_out_bits_last    (out_last),
      .io_out_bits_src     (out_src)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] off, input logic [7:0] last,
                           input logic [7:0] src);
      chk({tag, "_valid"}, 8'(out_valid), 8'd1);
      chk({tag, "_off"}, 8'(out_offset), off);
      chk({tag, "_last"}, 8'(out_last), last);
      chk({tag, "_src"}, 8'(out_src), src);
      chk({tag, "_rdy0"}, 8'(rdy0), 8'd0);
      chk({tag, "_rdy1"}, 8'(rdy1), 8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_src;
      logic [7:0] wrap_off [4];
      logic [7:0] wrap_last [4];
      wrap_off  = '{8'd6, 8'd7, 8'd0, 8'd1};
      wrap_last = '{8'd0, 8'd0, 8'd0, 8'd1};

      reset = 1'b0; out_ready = 1'b1;
      v0 = 0; id0 = 0; off0 = '0; len0 = '0;
      v1 = 0; id1 = 0; off1 = '0; len1 = '0;

      // Reset state
      next_cycle(); next_cycle(); settle();
      chk("rst_valid", 8'(out_valid), 8'd0);
      chk("rst_off", 8'(out_offset), 8'd0);
      chk("rst_last", 8'(out_last), 8'd0);
      chk("rst_id", 8'(out_id), 8'd0);
      chk("rst_src", 8'(out_src), 8'd0);
      chk("rst_rdy0", 8'(rdy0), 8'd0);
      chk("rst_rdy1", 8'(rdy1), 8'd0);

      // Single-beat burst from requester 0
      reset = 1'b1; v0 = 1; id0 = 1; off0 = 3'd2; len0 = 3'd0; settle();
      chk("sb_rdy0", 8'(rdy0), 8'd1);
      chk("sb_rdy1", 8'(rdy1), 8'd0);
      chk("sb_idle_valid", 8'(out_valid), 8'd0);
      next_cycle(); v0 = 0; settle();
      chk_beat("sb_beat", 8'd2, 8'd1, 8'd0);
      chk("sb_id", 8'(out_id), 8'd1);
      next_cycle(); settle();
      chk("sb_back_idle", 8'(out_valid), 8'd0);

      // Both requesters continuously valid: grants alternate 0,1,0,1
      reset = 1'b0; next_cycle(); reset = 1'b1;
      v0 = 1; id0 = 0; off0 = 3'd0; len0 = 3'd1;
      v1 = 1; id1 = 1; off1 = 3'd4; len1 = 3'd1;
      settle();
      for (int k = 0; k < 4; k++) begin
         exp_src = 8'(k % 2);
         chk("alt_rdy0", 8'(rdy0), 8'(exp_src == 0));
         chk("alt_rdy1", 8'(rdy1), 8'(exp_src == 1));
         chk("alt_bubble", 8'(out_valid), 8'd0);
         next_cycle(); settle();
         chk_beat("alt_b0", (exp_src == 1) ? 8'd4 : 8'd0, 8'd0, exp_src);
         chk("alt_id", 8'(out_id), exp_src);
         next_cycle(); settle();
         chk_beat("alt_b1", (exp_src == 1) ? 8'd5 : 8'd1, 8'd1, exp_src);
         next_cycle(); settle();
      end
      v0 = 0; v1 = 0; settle();
      chk("alt_end_valid", 8'(out_valid), 8'd0);

      // Wrapping burst from requester 1: offsets 6,7,0,1
      v1 = 1; id1 = 0; off1 = 3'd6; len1 = 3'd3; settle();
      chk("wrap_rdy1", 8'(rdy1), 8'd1);
      chk("wrap_rdy0", 8'(rdy0), 8'd0);
      next_cycle(); v1 = 0; settle();
      for (int i = 0; i < 4; i++) begin
         chk_beat("wrap", wrap_off[i], wrap_last[i], 8'd1);
         next_cycle(); settle();
      end
      chk("wrap_end_valid", 8'(out_valid), 8'd0);

      // Stall mid-burst, with new commands arriving that must wait
      v0 = 1; id0 = 1; off0 = 3'd3; len0 = 3'd2; settle();
      chk("stall_rdy0", 8'(rdy0), 8'd1);
      next_cycle(); v0 = 0; settle();
      chk_beat("stall_b0", 8'd3, 8'd0, 8'd0);
      next_cycle();
      out_ready = 1'b0;
      v1 = 1; id1 = 1; off1 = 3'd5; len1 = 3'd0;
      v0 = 1; id0 = 0; off0 = 3'd0; len0 = 3'd0;
      settle();
      for (int i = 0; i < 3; i++) begin
         chk_beat("stall_hold", 8'd4, 8'd0, 8'd0);
         chk("stall_id", 8'(out_id), 8'd1);
         next_cycle(); settle();
      end
      out_ready = 1'b1; settle();
      chk_beat("stall_resume", 8'd4, 8'd0, 8'd0);
      next_cycle(); settle();
      chk_beat("stall_b2", 8'd5, 8'd1, 8'd0);
      next_cycle(); settle();
      chk("pend_valid", 8'(out_valid), 8'd0);
      chk("pend_rdy1", 8'(rdy1), 8'd1);
      chk("pend_rdy0", 8'(rdy0), 8'd0);
      next_cycle(); v1 = 0; settle();
      chk_beat("pend_b1", 8'd5, 8'd1, 8'd1);
      chk("pend_id", 8'(out_id), 8'd1);
      next_cycle(); settle();
      chk("pend2_valid", 8'(out_valid), 8'd0);
      chk("pend2_rdy0", 8'(rdy0), 8'd1);
      next_cycle(); v0 = 0; settle();
      chk_beat("pend2_b0", 8'd0, 8'd1, 8'd0);
      next_cycle(); settle();
      chk("pend2_end", 8'(out_valid), 8'd0);

      // Reset on the second beat of a 4-beat burst aborts it
      v0 = 1; id0 = 0; off0 = 3'd0; len0 = 3'd3; settle();
      chk("abort_rdy0", 8'(rdy0), 8'd1);
      next_cycle(); v0 = 0; settle();
      chk_beat("abort_b0", 8'd0, 8'd0, 8'd0);
      next_cycle(); settle();
      chk_beat("abort_b1", 8'd1, 8'd0, 8'd0);
      reset = 1'b0;
      next_cycle(); settle();
      chk("abort_valid", 8'(out_valid), 8'd0);
      chk("abort_off", 8'(out_offset), 8'd0);
      reset = 1'b1; v0 = 1; v1 = 1; settle();
      chk("abort_ptr_rdy0", 8'(rdy0), 8'd1);
      chk("abort_ptr_rdy1", 8'(rdy1), 8'd0);
      v0 = 0; v1 = 0; settle();
      next_cycle(); settle();
      chk("abort_quiet", 8'(out_valid), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/burst_rr_arbiter.md
BURST_RR_ARBITER -- requirements
Module: BurstRRArbiter

Interface
REQ-001 Parameter: OFFSET_W, default 3, width of offset and length fields; burst offset wraps modulo 2^OFFSET_W.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 io_in_N_valid  input  1  (N=0,1) requester N presents a burst command.
REQ-005 io_in_N_bits_id  input  1  transaction id of requester N's command.
REQ-006 io_in_N_bits_offset  input  OFFSET_W  start offset of requester N's burst.
REQ-007 io_in_N_bits_len  input  OFFSET_W  beat count minus one (0 means 1 beat, 7 means 8 beats).
REQ-008 io_in_N_ready  output  1  command of requester N accepted this cycle.
REQ-009 io_out_ready  input  1  downstream accepts the current beat.
REQ-010 io_out_valid  output  1  a beat is presented.
REQ-011 io_out_bits_id  output  1  id of the active burst.
REQ-012 io_out_bits_offset  output  OFFSET_W  offset of the current beat.
REQ-013 io_out_bits_last  output  1  current beat is the final beat of the burst.
REQ-014 io_out_bits_src  output  1  index of the requester that owns the active burst.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE, io_out_valid SHALL be 0, and the block SHALL grant at most one requester per cycle using round-robin priority.
REQ-017 Round-robin: the requester not granted most recently SHALL have priority; the other requester SHALL be granted only when the priority requester is not valid.
REQ-018 In IDLE, io_in_N_ready SHALL be 1 only for the granted requester, combinationally from the valids and the priority pointer; it SHALL not depend on io_out_ready.
REQ-019 On accept (IDLE, valid & ready): id, start offset, len and src SHALL be captured; the beat counter SHALL clear to 0; the priority pointer SHALL be updated to favour the other requester; the state SHALL go to BURST.
REQ-020 The first beat SHALL appear on io_out the cycle after accept (latency 1).
REQ-021 In BURST: io_out_valid SHALL be 1; both io_in_N_ready SHALL be 0; offset = (start + beat) mod 2^OFFSET_W; last = (beat == len).
REQ-022 Output fields SHALL hold stable while io_out_valid=1 and io_out_ready=0.
REQ-023 On out fire with last=0, the beat counter SHALL increment by 1.
REQ-024 On out fire with last=1, the state SHALL return to IDLE; the next command SHALL not be accepted in that same cycle, giving one idle bubble between bursts.
REQ-025 Offset wrap: start=6, len=3 SHALL produce offsets 6,7,0,1.
REQ-026 Requester valids arriving during BURST SHALL wait; no command SHALL be dropped or accepted twice.

Reset
REQ-027 While reset=0 at a clock edge: state=IDLE, beat counter=0, priority pointer favours requester 0, captured fields=0.
REQ-028 Outputs after reset: io_out_valid=0, io_out_bits_*=0, io_in_N_ready per REQ-018.
REQ-029 Reset asserted mid-burst SHALL abort the burst; remaining beats SHALL not be emitted.

Structure
REQ-030 The FSM state enum and the OFFSET_W default SHALL live in the shared package used by the arbiter family.
REQ-031 The round-robin grant logic (2 valids + pointer -> one-hot grant) SHALL be a sub-module named RRGrant2; the FSM and beat counter SHALL stay in BurstRRArbiter.

Verification
REQ-032 Reset, then in_0 {id=1, off=2, len=0}, out_ready=1 -> in_0_ready=1 in cycle 0; in cycle 1 one beat {id=1, off=2, last=1, src=0}; IDLE in cycle 2.
REQ-033 Both valid continuously, each with len=1, out_ready=1 -> grants alternate 0,1,0,1; each burst is 2 beats followed by 1 bubble.
REQ-034 in_1 {off=6, len=3} -> offsets 6,7,0,1; last only on the beat with offset 1.
REQ-035 out_ready=0 for 3 cycles mid-burst -> the beat is held stable and the beat counter does not advance; no in_ready asserted.
REQ-036 Reset asserted on the 2nd beat of a 4-beat burst -> out_valid=0 the next cycle; pointer favours requester 0.
REQ-037 in_0 valid alone, accepted, then in_1 valid during the burst -> in_1 granted first in the next IDLE.
